// File: rtl/key_edge_capture_pkg.sv
// key_edge_capture_pkg: I/O address map and data width shared by the system top and the key peripheral.
package key_edge_capture_pkg;
    localparam int DATA_W = 16;
    typedef logic [DATA_W-1:0] word_t;
    localparam word_t KEY_ADDR  = 16'hFFFF;
    localparam word_t SW_ADDR   = 16'hFFFE;
    localparam word_t LEDR_ADDR = 16'hFFFD;
    localparam word_t HEX_ADDR  = 16'hFFFC;
    localparam word_t EDGE_ADDR = 16'hFFFA;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchronizer plus consecutive-cycle debounce for one pressed-high key.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_key,
    output logic o_stable,
    output logic o_rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_stable;
    logic          w_diff;
    logic          w_done;
    assign w_diff = r_sync[1] != r_stable;
    assign w_done = w_diff && r_cnt == LAST;
    // Rise is flagged in the cycle whose closing edge updates stable, so the edge register sets alongside it.
    assign o_rise   = w_done && r_sync[1];
    assign o_stable = r_stable;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], i_key};
            r_cnt    <= (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
            if (w_done) r_stable <= r_sync[1];
        end
    end
endmodule

// File: rtl/key_edge_capture.sv
// key_edge_capture: debounced push-button levels plus a sticky W1C press-event register on the CPU I/O bus.
module key_edge_capture
    import key_edge_capture_pkg::*;
#(
    parameter int    N_KEYS          = 4,
    parameter int    DEBOUNCE_CYCLES = 500000,
    parameter word_t LEVEL_ADDR      = key_edge_capture_pkg::KEY_ADDR,
    parameter word_t EDGE_ADDR       = key_edge_capture_pkg::EDGE_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_n,
    input  word_t             mem_addr,
    input  logic              mem_wr_en,
    input  word_t             mem_wr_data,
    output word_t             rd_data,
    output logic              rd_hit,
    output logic              pending
);
    logic [N_KEYS-1:0] w_stable;
    logic [N_KEYS-1:0] w_rise;
    word_t             w_clr;
    word_t             r_edge;
    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk),
            .reset   (reset),
            .i_key   (~key_n[i]),
            .o_stable(w_stable[i]),
            .o_rise  (w_rise[i])
        );
    end
    // Edge bits above N_KEYS-1 never set, so they stay 0 and ignore write data there.
    assign w_clr = (mem_wr_en && mem_addr == EDGE_ADDR) ? mem_wr_data : '0;
    always_ff @(posedge clk) begin
        if (reset) r_edge <= '0;
        else       r_edge <= (r_edge & ~w_clr) | DATA_W'(w_rise);
    end
    always_comb begin
        rd_data = mem_addr == LEVEL_ADDR ? DATA_W'(w_stable) :
                  mem_addr == EDGE_ADDR  ? r_edge : '0;
        rd_hit  = mem_addr == LEVEL_ADDR || mem_addr == EDGE_ADDR;
        pending = |r_edge;
    end
endmodule

// File: doc/key_edge_capture.md
Name: key_edge_capture

Overview:
- Memory-mapped push-button peripheral for the CPU system's I/O space; sits upstream of the I/O read-data mux.
- Synchronizes and debounces the active-low KEY inputs.
- Latches press events in a sticky edge register that the CPU reads and clears with write-1-to-clear.
- Exposes a combinational read path and an any-pending flag for polling loops.

Parameters:
- N_KEYS, 4, number of key inputs (1..16).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be >= 1.
- LEVEL_ADDR, 16'hFFFF, read-only address returning the debounced pressed levels.
- EDGE_ADDR, 16'hFFFA, read/W1C address for the sticky press-event register.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous active-high reset.
- key_n  input  N_KEYS  raw asynchronous buttons, 0 = pressed.
- mem_addr  input  16  CPU data address.
- mem_wr_en  input  1  CPU store strobe.
- mem_wr_data  input  16  CPU store data.
- rd_data  output  16  read data for the addressed register, 0 when not selected.
- rd_hit  output  1  high when mem_addr equals LEVEL_ADDR or EDGE_ADDR.
- pending  output  1  OR of all edge bits.

Behaviour:
- Synchronizer: two flops per key on ~key_n, so 1 = pressed. Reset clears both flops to 0.
- Debounce, per key:
  - State is stable[i] plus a counter of width $clog2(DEBOUNCE_CYCLES)+1.
  - If sync[i] == stable[i], the counter is set to 0.
  - Otherwise the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and sync still differs: stable[i] <= sync[i] and the counter returns to 0.
  - Any return to equality before that restarts the count. There is no partial credit.
- Latency: a clean press on key_n appears on stable 2 + DEBOUNCE_CYCLES cycles later, because the register updates on the edge ending the DEBOUNCE_CYCLES-th differing cycle.
- Edge register edge[N_KEYS-1:0]:
  - Bit i sets on the cycle stable[i] transitions 0->1.
  - Release (1->0) never sets a bit.
  - A bit stays set until cleared.
- Clear:
  - Fires when mem_wr_en && mem_addr == EDGE_ADDR.
  - Each edge[i] with mem_wr_data[i] == 1 is cleared on that clock edge. Bits with 0 are unaffected.
  - Data bits above N_KEYS-1 are ignored.
- Simultaneous set and clear of the same bit in one cycle: set wins, so the bit stays 1.
- Writes to LEVEL_ADDR and to any other address have no effect.
- Read path is purely combinational on mem_addr:
  - LEVEL_ADDR -> zero-extended stable.
  - EDGE_ADDR -> zero-extended edge.
  - Any other address -> 16'h0000 with rd_hit = 0.
- pending = |edge, registered-state derived, with no extra latency.
- Reset: sync, stable, counters and edge all go to 0. Consequently rd_data = 0 for all addresses and pending = 0.
  - Reset asserted mid-count aborts the count.
  - A key held through reset is re-accepted 2 + DEBOUNCE_CYCLES cycles after reset deasserts and sets its edge bit.
- Keys are fully independent. Multiple keys may change stable and set edge bits in the same cycle.

Decomposition:
- Shared package holds:
  - the I/O address constants (KEY/SW/LEDR/HEX addresses plus EDGE_ADDR 16'hFFFA), so the system top and this block agree;
  - the data width constant 16.
- One natural sub-module: key_debounce, a single-bit synchronizer plus debounce counter with parameter DEBOUNCE_CYCLES and outputs stable and rise (a one-cycle pulse on 0->1). It is instantiated N_KEYS times via generate.
- The top level owns the edge register, W1C logic and read mux.

Test Plan (DEBOUNCE_CYCLES = 8, N_KEYS = 4):
- Reset: hold reset 3 cycles with key_n = 4'hF -> rd_data = 0 at 16'hFFFF and 16'hFFFA, pending = 0, rd_hit = 1 only at those two addresses.
- Clean press: drive key_n[1] = 0 and hold.
  - Read 16'hFFFF -> 16'h0002 exactly 10 cycles after the input change, not at 9.
  - Read 16'hFFFA -> 16'h0002; pending = 1.
- Bounce rejection: toggle key_n[0] every 3 cycles for 30 cycles, then release -> stable[0] stays 0, edge stays 16'h0000, pending = 0.
- W1C and write isolation: with edge = 16'h0003:
  - write 16'h0001 to 16'hFFFA -> reads 16'h0002;
  - write 16'hFFFF to 16'hFFFF -> no change;
  - write 16'hFFF0 to 16'hFFFA -> no change.
- Set/clear collision: schedule a write of 16'h0004 to 16'hFFFA on the same cycle stable[2] rises -> edge bit 2 reads 1 afterwards. Release of key 2 produces no new edge.
- Reset mid-operation: press key 3 and assert reset for 1 cycle after 5 debounce cycles -> level stays 0 and the count restarts. With the key still held, level reads 16'h0008 and edge bit 3 sets 10 cycles after reset deasserts.
